// File: rtl/timer_irq_ctrl.sv
// Programmable down-counting timer with periodic/one-shot modes and a level irq/ack handshake.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module timer_irq_ctrl #(
  parameter int unsigned       CNT_W          = 8,
  parameter int unsigned       PRESC_W        = 8,
  parameter logic [CNT_W-1:0]  RELOAD_DEFAULT = CNT_W'('h0F)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_reload,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_periodic,
  input  logic               irq_ack,
  output logic [CNT_W-1:0]   count,
  output logic               irq,
  output logic               irq_overrun,
  output logic               running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] count_d, reload_reg, reload_d;
  logic             periodic_reg, periodic_d;
  logic             irq_d, overrun_d;
  logic             tick, expire;

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_reg, presc_reg_d, presc_cnt, presc_cnt_d;
`else
  logic unused_cfg_presc;
  assign unused_cfg_presc = ^cfg_presc;
`endif

  // A config write wins over any tick on the same edge.
  always_comb begin
`ifdef TIMER_PRESCALER_EN
    tick = (state == RUN) && enable && !cfg_we && (presc_cnt == presc_reg);
`else
    tick = (state == RUN) && enable && !cfg_we;
`endif
    expire = tick && (count == '0);
  end

  always_comb begin
    state_d    = state;
    count_d    = count;
    reload_d   = reload_reg;
    periodic_d = periodic_reg;
    irq_d      = irq;
    overrun_d  = irq_overrun;
`ifdef TIMER_PRESCALER_EN
    presc_reg_d = presc_reg;
    presc_cnt_d = '0;
    if ((state == RUN) && enable && !cfg_we)
      presc_cnt_d = (presc_cnt == presc_reg) ? '0 : presc_cnt + PRESC_W'(1);
`endif

    if (!cfg_we) begin
      unique case (state)
        IDLE: if (enable) state_d = RUN;
        RUN: begin
          if (!enable)
            state_d = IDLE;
          else if (expire && !periodic_reg)
            state_d = DONE;
        end
        DONE: if (!enable) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (cfg_we) begin
      reload_d   = cfg_reload;
      periodic_d = cfg_periodic;
      count_d    = cfg_reload;
`ifdef TIMER_PRESCALER_EN
      presc_reg_d = cfg_presc;
`endif
    end else if (tick) begin
      if (count != '0)
        count_d = count - CNT_W'(1);
      else if (periodic_reg)
        count_d = reload_reg;
    end else if ((state == DONE) && !enable) begin
      count_d = reload_reg;
    end

    // An expiry coinciding with an ack keeps irq set and does not count as overrun.
    if (expire)
      irq_d = 1'b1;
    else if (irq_ack)
      irq_d = 1'b0;

    if (cfg_we)
      overrun_d = 1'b0;
    else if (expire && irq && !irq_ack)
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= RELOAD_DEFAULT;
      reload_reg   <= RELOAD_DEFAULT;
      periodic_reg <= 1'b1;
      irq          <= 1'b0;
      irq_overrun  <= 1'b0;
      running      <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      presc_reg    <= '0;
      presc_cnt    <= '0;
`endif
    end else begin
      state        <= state_d;
      count        <= count_d;
      reload_reg   <= reload_d;
      periodic_reg <= periodic_d;
      irq          <= irq_d;
      irq_overrun  <= overrun_d;
      running      <= (state_d == RUN);
`ifdef TIMER_PRESCALER_EN
      presc_reg    <= presc_reg_d;
      presc_cnt    <= presc_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed self-checking bench for timer_irq_ctrl; expected values are hand-derived.
module tb_timer_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, cfg_we, cfg_periodic, irq_ack;
  logic [7:0] cfg_reload, cfg_presc;
  logic [7:0] count;
  logic       irq, irq_overrun, running;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  timer_irq_ctrl #(.CNT_W(8), .PRESC_W(8), .RELOAD_DEFAULT(8'h0F)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_reload(cfg_reload), .cfg_presc(cfg_presc), .cfg_periodic(cfg_periodic),
    .irq_ack(irq_ack), .count(count), .irq(irq), .irq_overrun(irq_overrun),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [7:0] rl, input logic [7:0] pr, input logic per);
    cfg_reload = rl; cfg_presc = pr; cfg_periodic = per; cfg_we = 1'b1;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] c, input logic i,
                         input logic o, input logic r);
    check({tag, ".count"},   count,       c);
    check({tag, ".irq"},     irq,         i);
    check({tag, ".overrun"}, irq_overrun, o);
    check({tag, ".running"}, running,     r);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_periodic = 1'b1;
    irq_ack = 1'b0; cfg_reload = '0; cfg_presc = '0;
    step(2);
    chk_all("reset", 8'h0F, 1'b0, 1'b0, 1'b0);

    // Default periodic countdown
    reset = 1'b0; enable = 1'b1;
    step(1);
    chk_all("run_entry", 8'h0F, 1'b0, 1'b0, 1'b1);
    for (int unsigned i = 1; i <= 15; i++) begin
      step(1);
      check($sformatf("down%0d", i), count, 8'h0F - 8'(i));
      check($sformatf("noirq%0d", i), irq, 1'b0);
    end
    step(1);
    chk_all("expiry16", 8'h0F, 1'b1, 1'b0, 1'b1);

    // Ack clears irq on the next edge
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk_all("ack", 8'h0E, 1'b0, 1'b0, 1'b1);

    // Two unacked periods -> overrun
    step(15);
    chk_all("period2", 8'h0F, 1'b1, 1'b0, 1'b1);
    step(16);
    chk_all("overrun", 8'h0F, 1'b1, 1'b1, 1'b1);
    cfg(8'h0F, 8'h00, 1'b1);
    chk_all("cfg_clr_ovr", 8'h0F, 1'b1, 1'b0, 1'b1);

    // Ack on the expiry edge: irq stays, no overrun
    step(15);
    check("pre_exp.count", count, 8'h00);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk_all("ack_on_expiry", 8'h0F, 1'b1, 1'b0, 1'b1);

    // Reset mid-run beats a simultaneous config write
    reset = 1'b1; cfg_reload = 8'h05; cfg_we = 1'b1;
    step(1);
    cfg_we = 1'b0;
    chk_all("reset_mid", 8'h0F, 1'b0, 1'b0, 1'b0);

    // One-shot reload 3
    reset = 1'b0; enable = 1'b0;
    cfg(8'h03, 8'h00, 1'b0);
    chk_all("os_cfg", 8'h03, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step(1);
    chk_all("os_run", 8'h03, 1'b0, 1'b0, 1'b1);
    step(3);
    chk_all("os_zero", 8'h00, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("os_done", 8'h00, 1'b1, 1'b0, 1'b0);
    step(2);
    chk_all("os_hold", 8'h00, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    step(1);
    chk_all("os_idle", 8'h03, 1'b1, 1'b0, 1'b0);

    // Disable mid-run holds count
    cfg(8'h05, 8'h00, 1'b1);
    irq_ack = 1'b1; enable = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk_all("hold_run", 8'h05, 1'b0, 1'b0, 1'b1);
    step(2);
    check("hold_dec", count, 8'h03);
    enable = 1'b0;
    step(2);
    chk_all("hold_stop", 8'h03, 1'b0, 1'b0, 1'b0);

    // Reload 0: expiry on every tick
    cfg(8'h00, 8'h00, 1'b1);
    enable = 1'b1;
    step(1);
    chk_all("r0_run", 8'h00, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("r0_exp1", 8'h00, 1'b1, 1'b0, 1'b1);
    step(1);
    chk_all("r0_exp2", 8'h00, 1'b1, 1'b1, 1'b1);

`ifdef TIMER_PRESCALER_EN
    // Prescaler 2, reload 1: decrement every 3 cycles, expiry every 6
    reset = 1'b1;
    step(1);
    reset = 1'b0; enable = 1'b0;
    cfg(8'h01, 8'h02, 1'b1);
    enable = 1'b1;
    step(1);
    chk_all("ps_run", 8'h01, 1'b0, 1'b0, 1'b1);
    step(2);
    check("ps_c2", count, 8'h01);
    step(1);
    check("ps_c3", count, 8'h00);
    step(2);
    chk_all("ps_c5", 8'h00, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("ps_exp6", 8'h01, 1'b1, 1'b0, 1'b1);
    step(5);
    check("ps_c11.irq", irq, 1'b1);
    check("ps_c11.count", count, 8'h00);
    step(1);
    chk_all("ps_exp12", 8'h01, 1'b1, 1'b1, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
